// File: rtl/if_id_queue_if.sv
// IF/ID queue handshake bundle: fetch-side push channel, decode-side pop
// channel, redirect flush and the occupancy count reported back to the pipeline.
interface if_id_queue_if #(
  parameter int IW    = 32,
  parameter int AW    = 32,
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_instr;
  logic [AW-1:0] in_addr;
  logic          in_kill;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_instr;
  logic [AW-1:0] out_addr;
  logic          out_bubble;
  logic [CW-1:0] count;

  // Pipeline side: fetch/decode/redirect logic driving the queue.
  modport master (
    output in_valid, in_instr, in_addr, in_kill, flush, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, out_bubble, count
  );

  // Queue side.
  modport slave (
    input  in_valid, in_instr, in_addr, in_kill, flush, out_ready,
    output in_ready, out_valid, out_instr, out_addr, out_bubble, count
  );
endinterface

// File: rtl/if_id_queue.sv
// IF/ID elastic queue: DEPTH-entry FIFO between fetch and decode with
// valid/ready on both sides, per-entry kill-to-NOP, whole-queue flush on
// redirect and an occupancy count. Outputs are driven combinationally from
// the head entry, so a push is visible to decode one edge later.
module if_id_queue #(
  parameter int            IW        = 32,
  parameter int            AW        = 32,
  parameter int            DEPTH     = 2,
  parameter logic [IW-1:0] NOP_INSTR = IW'(32'h00000013)
) (
  input  logic         clk,
  input  logic         rst_n,
  if_id_queue_if.slave q
);

  // Pointer width; DEPTH is a power of two, so pointers wrap naturally.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic [IW-1:0]    mem_instr [DEPTH];
  logic [AW-1:0]    mem_addr  [DEPTH];
  logic [DEPTH-1:0] mem_kill;

  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic          out_valid;
  logic [IW-1:0] out_instr;
  logic [AW-1:0] out_addr;
  logic          out_bubble;

  // in_ready looks only at registered occupancy, so a full queue refuses a
  // push even when decode frees a slot in the same cycle.
  assign empty = (count == '0);
  assign full  = (count == FULL_COUNT);
  assign push  = q.in_valid & ~full & ~q.flush;
  assign pop   = ~empty & q.out_ready & ~q.flush;

  // Pointer and occupancy bookkeeping; flush empties the queue and overrides
  // any push or pop in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (q.flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage is deliberately not reset; occupancy alone says what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr] <= q.in_instr;
      mem_addr[wr_ptr]  <= q.in_addr;
      mem_kill[wr_ptr]  <= q.in_kill;
    end
  end

  // Head presentation: empty shows NOP at address 0, a killed head shows NOP
  // but keeps its address and raises out_bubble.
  always_comb begin
    out_valid  = ~empty;
    out_instr  = NOP_INSTR;
    out_addr   = '0;
    out_bubble = 1'b0;
    if (!empty) begin
      out_addr   = mem_addr[rd_ptr];
      out_bubble = mem_kill[rd_ptr];
      if (!mem_kill[rd_ptr]) begin
        out_instr = mem_instr[rd_ptr];
      end
    end
  end

  assign q.in_ready   = ~full;
  assign q.out_valid  = out_valid;
  assign q.out_instr  = out_instr;
  assign q.out_addr   = out_addr;
  assign q.out_bubble = out_bubble;
  assign q.count      = count;

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: a DEPTH=2 and a DEPTH=4 instance share one stimulus
// stream; each has its own expected-entry queue that a monitor drains.
module tb_if_id_queue;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        bubble;
  } exp_t;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_kill = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [31:0] in_addr = '0;

  int vectors = 0;
  int miscompares = 0;
  int depth [2] = '{2, 4};

  exp_t sb2 [$];
  exp_t sb4 [$];

  // Clock generation.
  always #5 clk = ~clk;

  if_id_queue_if #(.IW(32), .AW(32), .DEPTH(2)) bus2 ();
  if_id_queue_if #(.IW(32), .AW(32), .DEPTH(4)) bus4 ();

  assign bus2.in_valid  = in_valid;
  assign bus2.in_instr  = in_instr;
  assign bus2.in_addr   = in_addr;
  assign bus2.in_kill   = in_kill;
  assign bus2.flush     = flush;
  assign bus2.out_ready = out_ready;
  assign bus4.in_valid  = in_valid;
  assign bus4.in_instr  = in_instr;
  assign bus4.in_addr   = in_addr;
  assign bus4.in_kill   = in_kill;
  assign bus4.flush     = flush;
  assign bus4.out_ready = out_ready;

  if_id_queue #(.IW(32), .AW(32), .DEPTH(2), .NOP_INSTR(NOP)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (bus2.slave)
  );

  if_id_queue #(.IW(32), .AW(32), .DEPTH(4), .NOP_INSTR(NOP)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (bus4.slave)
  );

  logic [1:0]  mo_valid;
  logic [1:0]  mo_in_ready;
  logic [1:0]  mo_bubble;
  logic [31:0] mo_instr [2];
  logic [31:0] mo_addr  [2];
  logic [2:0]  mo_count [2];

  assign mo_valid[0]    = bus2.out_valid;
  assign mo_valid[1]    = bus4.out_valid;
  assign mo_in_ready[0] = bus2.in_ready;
  assign mo_in_ready[1] = bus4.in_ready;
  assign mo_bubble[0]   = bus2.out_bubble;
  assign mo_bubble[1]   = bus4.out_bubble;
  assign mo_instr[0]    = bus2.out_instr;
  assign mo_instr[1]    = bus4.out_instr;
  assign mo_addr[0]     = bus2.out_addr;
  assign mo_addr[1]     = bus4.out_addr;
  assign mo_count[0]    = {1'b0, bus2.count};
  assign mo_count[1]    = bus4.count;

  function automatic int sbSize(input int k);
    return (k == 0) ? sb2.size() : sb4.size();
  endfunction

  function automatic void sbPush(input int k, input exp_t e);
    if (k == 0) sb2.push_back(e);
    else        sb4.push_back(e);
  endfunction

  function automatic exp_t sbPop(input int k);
    if (k == 0) return sb2.pop_front();
    return sb4.pop_front();
  endfunction

  function automatic void sbClear();
    sb2.delete();
    sb4.delete();
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // One cycle of stimulus, applied just after a rising edge; entries accepted
  // at the next edge are pushed onto the expected queues, a flush empties them.
  task automatic applyStimulus(input logic v, input logic [31:0] instr,
                               input logic [31:0] addr, input logic kill,
                               input logic fl, input logic ordy);
    logic [1:0] acc;
    in_valid  = v;
    in_instr  = instr;
    in_addr   = addr;
    in_kill   = kill;
    flush     = fl;
    out_ready = ordy;
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("in_ready[D%0d]", depth[k]), 64'(mo_in_ready[k]),
                  64'(sbSize(k) != depth[k]));
      acc[k] = v && (sbSize(k) != depth[k]) && !fl;
    end
    @(posedge clk);
    if (fl) begin
      sbClear();
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (acc[k]) sbPush(k, {(kill ? NOP : instr), addr, kill});
      end
    end
    #1;
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, ordy);
  endtask

  // Checks the empty/reset output values on both instances without any clock edge.
  task automatic checkEmpty(input string tag);
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("%s_count[D%0d]", tag, depth[k]), 64'(mo_count[k]), 64'd0);
      checkOutput($sformatf("%s_valid[D%0d]", tag, depth[k]), 64'(mo_valid[k]), 64'd0);
      checkOutput($sformatf("%s_instr[D%0d]", tag, depth[k]), 64'(mo_instr[k]), 64'(NOP));
      checkOutput($sformatf("%s_addr[D%0d]", tag, depth[k]), 64'(mo_addr[k]), 64'd0);
      checkOutput($sformatf("%s_bubble[D%0d]", tag, depth[k]), 64'(mo_bubble[k]), 64'd0);
      checkOutput($sformatf("%s_in_ready[D%0d]", tag, depth[k]), 64'(mo_in_ready[k]), 64'd1);
    end
  endtask

  // Monitor: mid-cycle, compare occupancy and head against the expected queue
  // and retire the head whenever decode takes it.
  always @(negedge clk) begin
    int   sz;
    exp_t e;
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        sz = sbSize(k);
        checkOutput($sformatf("count[D%0d]", depth[k]), 64'(mo_count[k]), 64'(sz));
        checkOutput($sformatf("out_valid[D%0d]", depth[k]), 64'(mo_valid[k]), 64'(sz != 0));
        if (sz == 0) begin
          checkOutput($sformatf("empty_instr[D%0d]", depth[k]), 64'(mo_instr[k]), 64'(NOP));
          checkOutput($sformatf("empty_addr[D%0d]", depth[k]), 64'(mo_addr[k]), 64'd0);
        end else begin
          checkOutput($sformatf("head_instr[D%0d]", depth[k]), 64'(mo_instr[k]),
                      64'(sbPeekInstr(k)));
          if (out_ready && !flush) begin
            e = sbPop(k);
            checkOutput($sformatf("pop_addr[D%0d]", depth[k]), 64'(mo_addr[k]), 64'(e.addr));
            checkOutput($sformatf("pop_bubble[D%0d]", depth[k]), 64'(mo_bubble[k]),
                        64'(e.bubble));
          end
        end
      end
    end
  end

  function automatic logic [31:0] sbPeekInstr(input int k);
    return (k == 0) ? sb2[0].instr : sb4[0].instr;
  endfunction

  // Watchdog so the bench always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios.
  initial begin
    #1 rst_n = 1'b0;
    #1 checkEmpty("reset");
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Streaming with decode always ready.
    applyStimulus(1'b1, 32'h00A00093, 32'h100, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h00B00113, 32'h104, 1'b0, 1'b0, 1'b1);
    checkOutput("stream_head_instr", 64'(mo_instr[0]), 64'h00B00113);
    checkOutput("stream_count", 64'(mo_count[0]), 64'd1);
    idle(2, 1'b1);

    // Backpressure: decode stalled, third instruction held by fetch.
    applyStimulus(1'b1, 32'h00100093, 32'h200, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h00200113, 32'h204, 1'b0, 1'b0, 1'b0);
    checkOutput("bp_full_count", 64'(mo_count[0]), 64'd2);
    checkOutput("bp_full_in_ready", 64'(mo_in_ready[0]), 64'd0);
    applyStimulus(1'b1, 32'h00300193, 32'h208, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h00300193, 32'h208, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h00300193, 32'h208, 1'b0, 1'b0, 1'b1);
    idle(5, 1'b1);

    // Kill: a bubble stays until decode pops it.
    applyStimulus(1'b1, 32'h00C00193, 32'h108, 1'b1, 1'b0, 1'b0);
    checkOutput("kill_instr", 64'(mo_instr[0]), 64'(NOP));
    checkOutput("kill_bubble", 64'(mo_bubble[0]), 64'd1);
    checkOutput("kill_addr", 64'(mo_addr[0]), 64'h108);
    idle(1, 1'b0);
    checkOutput("kill_held_valid", 64'(mo_valid[0]), 64'd1);
    idle(2, 1'b1);

    // Flush with a full queue, an incoming instruction and decode ready.
    applyStimulus(1'b1, 32'h00400093, 32'h300, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h00500113, 32'h304, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h00D00213, 32'h308, 1'b0, 1'b1, 1'b1);
    checkOutput("flush_count", 64'(mo_count[0]), 64'd0);
    checkOutput("flush_valid", 64'(mo_valid[0]), 64'd0);
    idle(3, 1'b1);

    // Asynchronous reset with two entries held.
    applyStimulus(1'b1, 32'h00600093, 32'h500, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h00700113, 32'h504, 1'b0, 1'b0, 1'b0);
    checkOutput("prereset_count", 64'(mo_count[0]), 64'd2);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 checkEmpty("midreset");
    sbClear();
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Pointer wrap with irregular decode readiness.
    for (int i = 0; i < 14; i++) begin
      applyStimulus(1'b1, 32'h00000093 | (32'(i) << 20), 32'h400 + 32'(4 * i),
                    (i == 5), 1'b0, 1'($urandom_range(0, 1)));
    end
    idle(8, 1'b1);
    checkEmpty("drained");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
